imem_responder: RTL and testbench
=================================

# imem_responder

Instruction-memory responder for the LC3B pipeline: the memory-side end of the fetch interface (`pc` out of the processor, `instr`/`imem_r` back in). It models a multi-cycle instruction memory. It samples the fetch address and counts a configurable access latency, then returns the instruction word with `imem_r` high. A fetch redirect or PC advance aborts and restarts the access. A side-band load port preloads program images for simulation benches and FPGA bring-up.

## Interface
- `LATENCY`, 2: cycles `imem_r` stays low after a new address is presented; legal 0..15.
- `DEPTH`, 4096: storage size in 16-bit words; power of 2.
- `BASE`, 16'h3000: byte address of word 0.
- `clk` input 1: the block's single clock; all state changes on posedge.
- `rst_n` input 1: asynchronous, active-low reset.
- `req` input 1: fetch stage wants an instruction at `pc` this cycle.
- `pc` input 16: byte address of the fetch.
- `instr` output 16: instruction word; valid only while `imem_r`=1.
- `imem_r` output 1: `instr` is valid for the current `pc`.
- `err` output 1: bad fetch flag, qualified by `imem_r`.
- `ld_we` input 1: program-load write strobe.
- `ld_addr` input 16: load byte address; same mapping as `pc`.
- `ld_data` input 16: load data word.

## Operation
- Index mapping: `idx = (addr - BASE) >> 1`, truncated to log2(DEPTH) bits; `addr[0]` is ignored.
- States:
  - IDLE: no access in progress.
  - BUSY: latency counting.
  - READY: data available.
- Registers:
  - `addr_q`: captured word index.
  - `cnt_q`: 4-bit wait counter.
- `hit = (idx(pc) == addr_q)`.
- IDLE, `req`=1: `addr_q`<=idx(pc), `cnt_q`<=1; go to READY if LATENCY<=1, else BUSY.
- BUSY, `req`=1, `hit`: `cnt_q`<=`cnt_q`+1; go to READY when `cnt_q`+1 == LATENCY.
- BUSY or READY, `req`=1, `!hit`: restart. Recapture `addr_q`, set `cnt_q`<=1, then go to READY if LATENCY<=1, else BUSY.
- Any state, `req`=0: go to IDLE.
- `imem_r = req & hit & (state==READY)`. This is combinational on `pc`, so `imem_r` drops in the same cycle `pc` changes.
- `instr` = `mem[addr_q]` when `imem_r` is high; otherwise 16'h0000 (NOP).
- LATENCY=0: the state machine is bypassed.
  - `imem_r = req`.
  - `instr = mem[idx(pc)]`, combinational.
- Load port:
  - Writes `mem[idx(ld_addr)]` <= `ld_data` at posedge when `ld_we`=1.
  - A load write with idx == `addr_q` while in BUSY or READY forces a restart (BUSY, `cnt_q`<=1), keeping fetch coherent with self-modifying code.
  - A load write and a `pc` change in the same cycle resolve as a single restart.

## Timing
- Reset (asynchronous, `rst_n`=0):
  - state=IDLE, `cnt_q`=0, `addr_q`=0.
  - `imem_r`=0, `instr`=16'h0000, `err`=0.
  - Memory contents are not reset.
- Latency: with `pc` presented in cycle 0 and held with `req`=1, `imem_r` is 0 in cycles 0..LATENCY-1 and 1 from cycle LATENCY onward.
- While `pc` and `req` are held, `imem_r` stays high every cycle. The fetch stage may stall indefinitely.
- A PC advance in READY costs a full LATENCY again. There is no prefetch.
- Reset deasserted mid-access: the access is lost; a new access starts from IDLE.
- `cnt_q` saturates at 15.

## Configuration
- `IMEM_BOUNDS_CHECK_EN` defined:
  - A fetch with `pc < BASE`, `pc >= BASE + 2*DEPTH`, or `pc[0]`=1 completes with normal latency.
  - It returns `instr` = 16'hF025 (TRAP x25, HALT) with `err`=1.
  - Load writes to out-of-range addresses are dropped.
- Undefined:
  - Addresses wrap modulo DEPTH and `pc[0]` is ignored.
  - `err` is tied to 0.

## Structure
- Shared header `lc3bp_defs.v` (include-guarded) holds:
  - state encodings `IMEM_IDLE`/`IMEM_BUSY`/`IMEM_READY`;
  - `LC3B_NOP` = 16'h0000;
  - `LC3B_TRAP_HALT` = 16'hF025.
- Sub-module `imem_array`: DEPTH x 16 storage, one synchronous write port, one asynchronous read port.
- `imem_responder` holds the FSM, counter, address compare and bounds check.

## Test plan
- Basic fetch: load x3000=16'h1021; LATENCY=2; `req`=1, `pc`=x3000 held → `imem_r`=0 in cycles 0 and 1, then 1 with `instr`=16'h1021 from cycle 2 on.
- Redirect: `pc` changes x3000→x3002 in cycle 1, before READY → `imem_r` stays 0 until cycle 3, then `instr`=mem[x3002].
- Stall and advance: hold x3000 in READY for 5 cycles → `imem_r` stays 1 throughout. Then step to x3002 → `imem_r`=0 for 2 cycles, then 1.
- LATENCY=0: `pc` x3000→x3002→x3004 on consecutive cycles → `imem_r`=1 every cycle with the matching word.
- Reset mid-access: `rst_n` low in cycle 1 → `imem_r`=0 and `instr`=0 immediately. After release, the same `pc` needs a full LATENCY.
- With `IMEM_BOUNDS_CHECK_EN`: `pc`=x2FFE or x3001 → after LATENCY, `imem_r`=1, `instr`=16'hF025, `err`=1. Without the macro: x3001 returns mem[x3000], `err`=0.

Source files
------------

// File: rtl/imem_responder_pkg.sv
// Shared types and constants for the LC3B instruction-memory responder.
package imem_responder_pkg;

  typedef enum logic [1:0] {
    IMEM_IDLE  = 2'd0,
    IMEM_BUSY  = 2'd1,
    IMEM_READY = 2'd2
  } imem_state_e;

  localparam logic [15:0] LC3B_NOP       = 16'h0000;
  localparam logic [15:0] LC3B_TRAP_HALT = 16'hF025;
  localparam logic [3:0]  CNT_MAX        = 4'hF;

endpackage

// File: rtl/imem_array.sv
// DEPTH x 16 instruction storage: one synchronous write port, one asynchronous read port.
module imem_array #(
  parameter int DEPTH = 4096,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [15:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [15:0]   rdata
);

  logic [15:0] mem [DEPTH];

  // NOTE: storage is deliberately not reset; clearing thousands of words would need a
  // reset fan-out to every cell, and program images are loaded after reset anyway.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/imem_responder.sv
// Multi-cycle instruction-memory responder for the LC3B fetch interface, with a side-band
// program-load port. Define IMEM_BOUNDS_CHECK_EN to trap out-of-range/odd fetches as HALT.
module imem_responder
  import imem_responder_pkg::*;
#(
  parameter int unsigned LATENCY = 2,
  parameter int unsigned DEPTH   = 4096,
  parameter logic [15:0] BASE    = 16'h3000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic [15:0] pc,
  output logic [15:0] instr,
  output logic        imem_r,
  output logic        err,
  input  logic        ld_we,
  input  logic [15:0] ld_addr,
  input  logic [15:0] ld_data
);

  localparam int         AW  = $clog2(DEPTH);
  localparam logic [4:0] LAT = 5'(LATENCY);

  imem_state_e   state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [3:0]    cnt_q, cnt_d;

  logic [AW-1:0] pc_idx, ld_idx, rd_idx;
  logic [15:0]   rd_data;
  logic          hit, oob_pc, ld_ok, ld_conflict;

  // Byte address to word index, relative to BASE and wrapped to the array size.
  assign pc_idx = AW'((pc - BASE) >> 1);
  assign ld_idx = AW'((ld_addr - BASE) >> 1);
  assign hit    = (pc_idx == addr_q);

`ifdef IMEM_BOUNDS_CHECK_EN
  function automatic logic out_of_range(input logic [15:0] a);
    return ({1'b0, a} < {1'b0, BASE}) ||
           ({1'b0, a} >= ({1'b0, BASE} + 17'(2 * DEPTH))) ||
           a[0];
  endfunction

  assign oob_pc = out_of_range(pc);
  assign ld_ok  = ld_we & ~out_of_range(ld_addr);
`else
  assign oob_pc = 1'b0;
  assign ld_ok  = ld_we;
`endif

  // A load landing on the word being fetched invalidates whatever the access has seen so far.
  assign ld_conflict = ld_ok && (ld_idx == addr_q) && (state_q != IMEM_IDLE);

  // With no latency the array is read straight from pc; otherwise from the captured index.
  assign rd_idx = (LATENCY == 0) ? pc_idx : addr_q;

  imem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk   (clk),
    .we    (ld_ok),
    .waddr (ld_idx),
    .wdata (ld_data),
    .raddr (rd_idx),
    .rdata (rd_data)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IMEM_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: every combinationally assigned signal gets a default first, so no path through
  // the block leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    if (!req) begin
      state_d = IMEM_IDLE;
    end else if (state_q == IMEM_IDLE || !hit || ld_conflict) begin
      // New access, redirect, or load collision: one restart covers all of them.
      addr_d  = pc_idx;
      cnt_d   = 4'd1;
      state_d = (LAT <= 5'd1) ? IMEM_READY : IMEM_BUSY;
    end else if (state_q == IMEM_BUSY) begin
      cnt_d = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 4'd1;
      if (({1'b0, cnt_q} + 5'd1) == LAT) state_d = IMEM_READY;
    end
  end

  always_comb begin
    imem_r = 1'b0;
    instr  = LC3B_NOP;
    err    = 1'b0;
    if (LATENCY == 0) imem_r = req;
    else              imem_r = req & hit & (state_q == IMEM_READY);
    if (imem_r) begin
      instr = oob_pc ? LC3B_TRAP_HALT : rd_data;
      err   = oob_pc;
    end
  end

endmodule

// File: tb/tb_imem_responder.sv
// Scoreboard bench for imem_responder: a LATENCY=2 instance and a LATENCY=0 instance
// share the load port; per-cycle expectations are queued and checked on the falling edge.
module tb_imem_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0, req0 = 1'b0, ld_we = 1'b0;
  logic [15:0] pc = '0, pc0 = '0, ld_addr = '0, ld_data = '0;
  logic [15:0] instr2, instr0;
  logic        r2, r0, e2, e0;

  imem_responder #(.LATENCY(2), .DEPTH(4096), .BASE(16'h3000)) dut2 (
    .clk(clk), .rst_n(rst_n), .req(req), .pc(pc), .instr(instr2), .imem_r(r2), .err(e2),
    .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data)
  );

  imem_responder #(.LATENCY(0), .DEPTH(4096), .BASE(16'h3000)) dut0 (
    .clk(clk), .rst_n(rst_n), .req(req0), .pc(pc0), .instr(instr0), .imem_r(r0), .err(e0),
    .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic        r;
    logic [15:0] i;
    logic        e;
    logic        r0;
    logic [15:0] i0;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  // Drive one cycle of stimulus just after the rising edge and queue its expected outputs.
  task automatic cyc(input logic rst_v, input logic req_v, input logic [15:0] pc_v,
                     input logic req0_v, input logic [15:0] pc0_v,
                     input logic we_v, input logic [15:0] la, input logic [15:0] ld,
                     input logic er, input logic [15:0] ei, input logic ee,
                     input logic er0, input logic [15:0] ei0, input string nm);
    exp_t x;
    @(posedge clk);
    #1;
    rst_n = rst_v; req = req_v; pc = pc_v; req0 = req0_v; pc0 = pc0_v;
    ld_we = we_v; ld_addr = la; ld_data = ld;
    x.nm = nm; x.r = er; x.i = ei; x.e = ee; x.r0 = er0; x.i0 = ei0;
    sb.push_back(x);
  endtask

  task automatic f2(input logic [15:0] pc_v, input logic er, input logic [15:0] ei,
                    input logic ee, input string nm);
    cyc(1'b1, 1'b1, pc_v, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0, er, ei, ee, 1'b0, 16'h0, nm);
  endtask

  task automatic f0(input logic [15:0] pc_v, input logic [15:0] ei0, input string nm);
    cyc(1'b1, 1'b0, 16'h0, 1'b1, pc_v, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b1, ei0, nm);
  endtask

  task automatic idle(input string nm);
    cyc(1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, nm);
  endtask

  task automatic load(input logic [15:0] a, input logic [15:0] d);
    cyc(1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1, a, d, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, "load");
  endtask

  always @(negedge clk) begin
    exp_t x;
    if (sb.size() > 0) begin
      x = sb.pop_front();
      total++;
      if ({r2, instr2, e2, r0, instr0, e0} !== {x.r, x.i, x.e, x.r0, x.i0, 1'b0}) begin
        bad++;
        $display("FAIL %s: got r=%b instr=%h err=%b r0=%b instr0=%h err0=%b, want r=%b instr=%h err=%b r0=%b instr0=%h err0=0",
                 x.nm, r2, instr2, e2, r0, instr0, e0, x.r, x.i, x.e, x.r0, x.i0);
      end
    end
  end

  initial begin
    // Reset values while rst_n is held low, including with a request present.
    cyc(1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, "reset_idle");
    cyc(1'b0, 1'b1, 16'h3000, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, "reset_req");

    load(16'h3000, 16'h1021);
    load(16'h3002, 16'h14A2);
    load(16'h3004, 16'h5263);
    load(16'h3006, 16'h0E05);

    // Basic fetch: two cycles of wait, then the word every cycle while held.
    f2(16'h3000, 1'b0, 16'h0000, 1'b0, "basic_c0");
    f2(16'h3000, 1'b0, 16'h0000, 1'b0, "basic_c1");
    f2(16'h3000, 1'b1, 16'h1021, 1'b0, "basic_c2");
    f2(16'h3000, 1'b1, 16'h1021, 1'b0, "basic_c3");
    idle("gap1");

    // Redirect before READY restarts the count at the new address.
    f2(16'h3000, 1'b0, 16'h0000, 1'b0, "redir_c0");
    f2(16'h3002, 1'b0, 16'h0000, 1'b0, "redir_c1");
    f2(16'h3002, 1'b0, 16'h0000, 1'b0, "redir_c2");
    f2(16'h3002, 1'b1, 16'h14A2, 1'b0, "redir_c3");
    idle("gap2");

    // Stall in READY for five cycles, then advance: full latency again.
    f2(16'h3000, 1'b0, 16'h0000, 1'b0, "stall_c0");
    f2(16'h3000, 1'b0, 16'h0000, 1'b0, "stall_c1");
    for (int k = 0; k < 5; k++) f2(16'h3000, 1'b1, 16'h1021, 1'b0, $sformatf("stall_hold%0d", k));
    f2(16'h3002, 1'b0, 16'h0000, 1'b0, "adv_c0");
    f2(16'h3002, 1'b0, 16'h0000, 1'b0, "adv_c1");
    f2(16'h3002, 1'b1, 16'h14A2, 1'b0, "adv_c2");
    idle("gap3");

    // Zero-latency instance: a new word every cycle.
    f0(16'h3000, 16'h1021, "lat0_3000");
    f0(16'h3002, 16'h14A2, "lat0_3002");
    f0(16'h3004, 16'h5263, "lat0_3004");
    f0(16'h3006, 16'h0E05, "lat0_3006");
    idle("gap4");

    // Reset mid-access drops the access; afterwards a full latency is needed again.
    f2(16'h3004, 1'b0, 16'h0000, 1'b0, "rst_c0");
    cyc(1'b0, 1'b1, 16'h3004, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, "rst_c1");
    cyc(1'b0, 1'b1, 16'h3004, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, "rst_c2");
    f2(16'h3004, 1'b0, 16'h0000, 1'b0, "rel_c0");
    f2(16'h3004, 1'b0, 16'h0000, 1'b0, "rel_c1");
    f2(16'h3004, 1'b1, 16'h5263, 1'b0, "rel_c2");
    idle("gap5");

    // Odd / below-base fetches.
    f2(16'h3001, 1'b0, 16'h0000, 1'b0, "odd_c0");
    f2(16'h3001, 1'b0, 16'h0000, 1'b0, "odd_c1");
`ifdef IMEM_BOUNDS_CHECK_EN
    f2(16'h3001, 1'b1, 16'hF025, 1'b1, "odd_c2");
    idle("gap6");
    f2(16'h2FFE, 1'b0, 16'h0000, 1'b0, "low_c0");
    f2(16'h2FFE, 1'b0, 16'h0000, 1'b0, "low_c1");
    f2(16'h2FFE, 1'b1, 16'hF025, 1'b1, "low_c2");
`else
    f2(16'h3001, 1'b1, 16'h1021, 1'b0, "odd_c2");
`endif
    idle("gap7");

    // Load to the word being held in READY forces a restart and returns the new data.
    f2(16'h3000, 1'b0, 16'h0000, 1'b0, "coh_c0");
    f2(16'h3000, 1'b0, 16'h0000, 1'b0, "coh_c1");
    f2(16'h3000, 1'b1, 16'h1021, 1'b0, "coh_c2");
    cyc(1'b1, 1'b1, 16'h3000, 1'b0, 16'h0, 1'b1, 16'h3000, 16'hABCD, 1'b1, 16'h1021, 1'b0, 1'b0, 16'h0, "coh_wr");
    f2(16'h3000, 1'b0, 16'h0000, 1'b0, "coh_c4");
    f2(16'h3000, 1'b1, 16'hABCD, 1'b0, "coh_c5");
    // Load and pc change together resolve as one restart.
    cyc(1'b1, 1'b1, 16'h3002, 1'b0, 16'h0, 1'b1, 16'h3002, 16'hBEEF, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, "both_c0");
    f2(16'h3002, 1'b0, 16'h0000, 1'b0, "both_c1");
    f2(16'h3002, 1'b1, 16'hBEEF, 1'b0, "both_c2");
    idle("gap8");

    for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge clk);
    #1;
    if (sb.size() > 0) begin
      bad++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
